sequential_to_simultaneous_reg_ps_last_opt: RTL and testbench



---
 rtl/sequential_to_simultaneous_reg_ps_last_opt_pkg.sv | 19 +
 rtl/sequential_to_simultaneous_reg_ps_last_opt_fifo_multi_ch.sv | 36 +++
 rtl/sequential_to_simultaneous_reg_ps_last_opt.sv | 67 ++++++
 tb/tb_sequential_to_simultaneous_reg_ps_last_opt.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sequential_to_simultaneous_reg_ps_last_opt_pkg.sv
// Shared helpers and constants for the serial-in, parallel-out shift register.
package sequential_to_simultaneous_reg_ps_last_opt_pkg;

  // Contents move toward slot 0; new samples enter the top slot.
  localparam int DIR_TO_LOW  = -1;
  // Contents move toward the top slot; new samples enter slot 0.
  localparam int DIR_TO_HIGH = 1;

  // Clamp a size parameter so that a zero or negative value still elaborates.
  function automatic int notBeingZero(input int value);
    return (value < 1) ? 1 : value;
  endfunction

  // Interpret an integer option as a boolean (any non-zero value is true).
  function automatic bit valToBool(input int value);
    return (value != 0);
  endfunction

endpackage

// File: rtl/sequential_to_simultaneous_reg_ps_last_opt_fifo_multi_ch.sv
// Multi-bit delay line with synchronous reset and an enable-gated advance.
module fifo_multi_ch
  import sequential_to_simultaneous_reg_ps_last_opt_pkg::*;
#(
  parameter int FIFO_LEN      = 1,
  parameter int FIFO_CH_WIDTH = 1
) (
  input  logic                                    clk,
  input  logic                                    in_ctr_Srst,
  input  logic                                    in_ctr_en,
  input  logic [notBeingZero(FIFO_CH_WIDTH)-1:0]  in,
  output logic [notBeingZero(FIFO_CH_WIDTH)-1:0]  out
);

  localparam int LEN   = notBeingZero(FIFO_LEN);
  localparam int WIDTH = notBeingZero(FIFO_CH_WIDTH);

  logic [WIDTH-1:0] r_stages [LEN];

  // Clear every stage on reset, otherwise advance the whole line by one when enabled.
  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      for (int i = 0; i < LEN; i++) begin
        r_stages[i] <= '0;
      end
    end else if (in_ctr_en) begin
      r_stages[0] <= in;
      for (int i = 1; i < LEN; i++) begin
        r_stages[i] <= r_stages[i-1];
      end
    end
  end

  assign out = r_stages[LEN-1];

endmodule

// File: rtl/sequential_to_simultaneous_reg_ps_last_opt.sv
// Serial-in, parallel-out shift register: collects SHIFT_LEN samples and shows
// them together on one flat bus, optionally passing the newest sample straight through.
module sequential_to_simultaneous_reg_ps_last_opt
  import sequential_to_simultaneous_reg_ps_last_opt_pkg::*;
#(
  parameter int DIRECTION    = -1,
  parameter int SHIFT_LEN    = 4,
  parameter int BIT_WIDTH    = 1,
  parameter int PASSING_LAST = 0
) (
  input  logic                                                       clk,
  input  logic                                                       in_ctr_Srst,
  input  logic                                                       in_ctr_en,
  input  logic                                                       in_ctr_sig,
  input  logic [notBeingZero(BIT_WIDTH)-1:0]                         in,
  output logic [notBeingZero(SHIFT_LEN)*notBeingZero(BIT_WIDTH)-1:0] out
);

  localparam int LEN   = notBeingZero(SHIFT_LEN);
  localparam int WIDTH = notBeingZero(BIT_WIDTH);
  localparam int DIR   = (DIRECTION == DIR_TO_HIGH) ? DIR_TO_HIGH : DIR_TO_LOW;
  localparam bit PASS  = valToBool(PASSING_LAST);
  // Slot where new samples enter, and the offset from any slot to its entry-side neighbour.
  localparam int ENTRY = (DIR == DIR_TO_LOW) ? LEN - 1 : 0;
  localparam int STEP  = (DIR == DIR_TO_LOW) ? 1 : -1;

  logic                   w_shift;
  logic [LEN*WIDTH-1:0]   w_slots;

  assign w_shift = in_ctr_en & in_ctr_sig;
  assign out     = w_slots;

  generate
    if (DIRECTION != DIR_TO_LOW && DIRECTION != DIR_TO_HIGH) begin : g_dirWarn
      $warning("sequential_to_simultaneous_reg_ps_last_opt: DIRECTION=%0d unsupported, using -1", DIRECTION);
    end

    for (genvar k = 0; k < LEN; k++) begin : g_slot
      if (PASS && k == ENTRY) begin : g_pass
        // The entry slot is a plain wire so the full word is visible before the edge.
        assign w_slots[k*WIDTH +: WIDTH] = in;
      end else begin : g_reg
        logic [WIDTH-1:0] w_d;
        if (k == ENTRY) begin : g_fromIn
          assign w_d = in;
        end else if (PASS && (k + STEP) == ENTRY) begin : g_fromBypass
          // Taking `in` directly rather than the bypass slot keeps out free of self-loops.
          assign w_d = in;
        end else begin : g_fromNeighbour
          assign w_d = w_slots[(k+STEP)*WIDTH +: WIDTH];
        end

        fifo_multi_ch #(
          .FIFO_LEN      (1),
          .FIFO_CH_WIDTH (WIDTH)
        ) u_stage (
          .clk         (clk),
          .in_ctr_Srst (in_ctr_Srst),
          .in_ctr_en   (w_shift),
          .in          (w_d),
          .out         (w_slots[k*WIDTH +: WIDTH])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_sequential_to_simultaneous_reg_ps_last_opt.sv
// Bench for the serial-in, parallel-out shift register across several parameter sets,
// using a sample-history reference model plus directed word checks.
module tb_sequential_to_simultaneous_reg_ps_last_opt;

  logic        clock = 1'b0;
  logic        srst = 1'b0;
  logic        enable = 1'b0;
  logic        strobe = 1'b0;
  logic [2:0]  inBus = 3'b000;

  logic [3:0]  out0;
  logic [3:0]  out1;
  logic [3:0]  out2;
  logic [5:0]  out3;
  logic [11:0] out4;
  logic [1:0]  out5;

  int compared = 0;
  int mismatched = 0;
  bit modelValid = 1'b0;
  logic [2:0] history [$];

  always #5 clock = ~clock;

  sequential_to_simultaneous_reg_ps_last_opt #(.DIRECTION(-1), .SHIFT_LEN(4), .BIT_WIDTH(1), .PASSING_LAST(0))
    dut0 (.clk(clock), .in_ctr_Srst(srst), .in_ctr_en(enable), .in_ctr_sig(strobe), .in(inBus[0:0]), .out(out0));
  sequential_to_simultaneous_reg_ps_last_opt #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(1), .PASSING_LAST(0))
    dut1 (.clk(clock), .in_ctr_Srst(srst), .in_ctr_en(enable), .in_ctr_sig(strobe), .in(inBus[0:0]), .out(out1));
  sequential_to_simultaneous_reg_ps_last_opt #(.DIRECTION(-1), .SHIFT_LEN(4), .BIT_WIDTH(1), .PASSING_LAST(1))
    dut2 (.clk(clock), .in_ctr_Srst(srst), .in_ctr_en(enable), .in_ctr_sig(strobe), .in(inBus[0:0]), .out(out2));
  sequential_to_simultaneous_reg_ps_last_opt #(.DIRECTION(-1), .SHIFT_LEN(3), .BIT_WIDTH(2), .PASSING_LAST(0))
    dut3 (.clk(clock), .in_ctr_Srst(srst), .in_ctr_en(enable), .in_ctr_sig(strobe), .in(inBus[1:0]), .out(out3));
  sequential_to_simultaneous_reg_ps_last_opt #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(3), .PASSING_LAST(1))
    dut4 (.clk(clock), .in_ctr_Srst(srst), .in_ctr_en(enable), .in_ctr_sig(strobe), .in(inBus), .out(out4));
  sequential_to_simultaneous_reg_ps_last_opt #(.DIRECTION(-1), .SHIFT_LEN(1), .BIT_WIDTH(2), .PASSING_LAST(1))
    dut5 (.clk(clock), .in_ctr_Srst(srst), .in_ctr_en(enable), .in_ctr_sig(strobe), .in(inBus[1:0]), .out(out5));

  // Expected word: the most recent registered samples (oldest first, zero-padded),
  // followed by the live input when it bypasses, laid out by direction.
  function automatic logic [11:0] modelOut(input int n, input int w, input int dir,
                                           input int pl, input logic [2:0] cur);
    logic [2:0]  full [$];
    logic [2:0]  s;
    logic [11:0] res;
    int          r;
    int          idx;
    res = '0;
    r = (pl != 0) ? n - 1 : n;
    for (int i = 0; i < r; i++) begin
      idx = history.size() - r + i;
      full.push_back((idx >= 0) ? history[idx] : 3'b000);
    end
    if (pl != 0) full.push_back(cur);
    for (int k = 0; k < n; k++) begin
      s = (dir < 0) ? full[k] : full[n-1-k];
      for (int b = 0; b < w; b++) res[k*w+b] = s[b];
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("dut0", {8'b0, out0}, modelOut(4, 1, -1, 0, inBus));
    checkOutput("dut1", {8'b0, out1}, modelOut(4, 1,  1, 0, inBus));
    checkOutput("dut2", {8'b0, out2}, modelOut(4, 1, -1, 1, inBus));
    checkOutput("dut3", {6'b0, out3}, modelOut(3, 2, -1, 0, inBus));
    checkOutput("dut4", out4,         modelOut(4, 3,  1, 1, inBus));
    checkOutput("dut5", {10'b0, out5}, modelOut(1, 2, -1, 1, inBus));
  endtask

  task automatic driveInputs(input logic rst, input logic en, input logic sig, input logic [2:0] value);
    @(negedge clock);
    srst = rst;
    enable = en;
    strobe = sig;
    inBus = value;
    #1;
    if (modelValid) checkAll();
  endtask

  task automatic clockEdge();
    @(posedge clock);
    if (srst) begin
      history.delete();
      modelValid = 1'b1;
    end else if (enable && strobe) begin
      history.push_back(inBus);
      if (history.size() > 8) void'(history.pop_front());
    end
    #1;
    if (modelValid) checkAll();
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic sig, input logic [2:0] value);
    driveInputs(rst, en, sig, value);
    clockEdge();
  endtask

  initial begin
    $display("[TB] start");

    // Reset with strobe and data active must still clear everything.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b001);

    // Shift 1,0,1 then present 1: the bypass variant shows the full word before the edge.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b001);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b001);
    driveInputs(1'b0, 1'b1, 1'b1, 3'b001);
    checkOutput("passLast_1101", {8'b0, out2}, 12'h00D);
    clockEdge();
    checkOutput("dirLow_1101", {8'b0, out0}, 12'h00D);
    checkOutput("dirHigh_1011", {8'b0, out1}, 12'h00B);

    // Hold: strobe low, then enable low, with changing data.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
    checkOutput("hold_1101", {8'b0, out0}, 12'h00D);

    // Reset in the middle of a collection discards partial contents and the coincident shift.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b001);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b001);
    checkOutput("midReset_dirLow", {8'b0, out0}, 12'h000);
    checkOutput("midReset_dirHigh", {8'b0, out1}, 12'h000);
    checkOutput("midReset_passLast", {8'b0, out2}, 12'h008);

    // Two-bit samples 01,10,11 land in slots 0,1,2.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b001);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b010);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b011);
    checkOutput("wide_111001", {6'b0, out3}, 12'h039);

    // Randomized traffic, with occasional resets and idle cycles.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
